// File: rtl/mcycle_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, instruction
// classes, opcode/funct values, ALU codes and datapath mux selects.
package mcycle_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CL_NONE, CL_RALU, CL_IALU, CL_LOAD, CL_STORE,
    CL_BEQ, CL_BNE, CL_J, CL_JR, CL_JAL, CL_JALR
  } class_e;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D, OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20, OP_LH   = 6'h21, OP_LW   = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24, OP_LHU  = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28, OP_SH   = 6'h29, OP_SW   = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04, F_SRLV = 6'h06, F_SRAV = 6'h07;
  localparam logic [5:0] F_JR   = 6'h08, F_JALR = 6'h09;
  localparam logic [5:0] F_ADD  = 6'h20, F_ADDU = 6'h21, F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23, F_AND  = 6'h24, F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26, F_NOR  = 6'h27, F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3, ALU_XOR = 4'd4, ALU_NOR = 4'd5;
  localparam logic [3:0] ALU_SLT = 4'd6, ALU_SLTU = 4'd7, ALU_SLL = 4'd8;
  localparam logic [3:0] ALU_SRL = 4'd9, ALU_SRA = 4'd10, ALU_LUI = 4'd11;

  localparam logic [1:0] NPC_PC4 = 2'd0, NPC_BR = 2'd1, NPC_JMP = 2'd2, NPC_RS = 2'd3;
  localparam logic [1:0] RD_RT = 2'd0, RD_RD = 2'd1, RD_RA = 2'd2;
  localparam logic [1:0] WD_ALU = 2'd0, WD_MDR = 2'd1, WD_PC = 2'd2;
  localparam logic [1:0] SZ_WORD = 2'd0, SZ_HALF = 2'd1, SZ_BYTE = 2'd2;

endpackage

// File: rtl/mcycle_decode.sv
// Combinational class decode of op/funct. Sub-word loads/stores decode only when
// MCYCLE_CTRL_SUBWORD_EN is defined; otherwise they fall out as illegal.
module mcycle_decode
  import mcycle_pkg::*;
#(
  parameter int ALUOP_W = 4
) (
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  output class_e             cls,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               ext_sel,
  output logic               alu_srca,
  output logic               shamt_var,
  output logic               shift_right,
  output logic               shift_arith,
  output logic [1:0]         sub_size,
  output logic               sub_unsign,
  output logic               legal
);

  logic [3:0] alu_code;

  always_comb begin
    cls         = CL_NONE;
    alu_code    = ALU_ADD;
    ext_sel     = 1'b0;
    alu_srca    = 1'b0;
    shamt_var   = 1'b0;
    shift_right = 1'b0;
    shift_arith = 1'b0;
    sub_size    = SZ_WORD;
    sub_unsign  = 1'b0;
    case (op)
      OP_RTYPE: begin
        cls = CL_RALU;
        case (funct)
          F_ADD, F_ADDU: alu_code = ALU_ADD;
          F_SUB, F_SUBU: alu_code = ALU_SUB;
          F_AND:         alu_code = ALU_AND;
          F_OR:          alu_code = ALU_OR;
          F_XOR:         alu_code = ALU_XOR;
          F_NOR:         alu_code = ALU_NOR;
          F_SLT:         alu_code = ALU_SLT;
          F_SLTU:        alu_code = ALU_SLTU;
          F_SLL, F_SLLV: begin
            alu_code  = ALU_SLL;
            alu_srca  = 1'b1;
            shamt_var = funct[2];
          end
          F_SRL, F_SRLV: begin
            alu_code    = ALU_SRL;
            alu_srca    = 1'b1;
            shamt_var   = funct[2];
            shift_right = 1'b1;
          end
          F_SRA, F_SRAV: begin
            alu_code    = ALU_SRA;
            alu_srca    = 1'b1;
            shamt_var   = funct[2];
            shift_right = 1'b1;
            shift_arith = 1'b1;
          end
          F_JR:    cls = CL_JR;
          F_JALR:  cls = CL_JALR;
          default: cls = CL_NONE;
        endcase
      end
      OP_ADDI: begin cls = CL_IALU; alu_code = ALU_ADD; ext_sel = 1'b1; end
      OP_SLTI: begin cls = CL_IALU; alu_code = ALU_SLT; ext_sel = 1'b1; end
      OP_ANDI: begin cls = CL_IALU; alu_code = ALU_AND; end
      OP_ORI:  begin cls = CL_IALU; alu_code = ALU_OR;  end
      OP_LUI:  begin cls = CL_IALU; alu_code = ALU_LUI; end
      OP_LW:   begin cls = CL_LOAD;  ext_sel = 1'b1; end
      OP_SW:   begin cls = CL_STORE; ext_sel = 1'b1; end
`ifdef MCYCLE_CTRL_SUBWORD_EN
      OP_LB:   begin cls = CL_LOAD;  ext_sel = 1'b1; sub_size = SZ_BYTE; end
      OP_LBU:  begin cls = CL_LOAD;  ext_sel = 1'b1; sub_size = SZ_BYTE; sub_unsign = 1'b1; end
      OP_LH:   begin cls = CL_LOAD;  ext_sel = 1'b1; sub_size = SZ_HALF; end
      OP_LHU:  begin cls = CL_LOAD;  ext_sel = 1'b1; sub_size = SZ_HALF; sub_unsign = 1'b1; end
      OP_SB:   begin cls = CL_STORE; ext_sel = 1'b1; sub_size = SZ_BYTE; end
      OP_SH:   begin cls = CL_STORE; ext_sel = 1'b1; sub_size = SZ_HALF; end
`endif
      OP_BEQ:  begin cls = CL_BEQ; alu_code = ALU_SUB; ext_sel = 1'b1; end
      OP_BNE:  begin cls = CL_BNE; alu_code = ALU_SUB; ext_sel = 1'b1; end
      OP_J:    cls = CL_J;
      OP_JAL:  cls = CL_JAL;
      default: cls = CL_NONE;
    endcase
  end

  assign alu_op = ALUOP_W'(alu_code);
  assign legal  = (cls != CL_NONE);

endmodule

// File: rtl/mcycle_ctrl.sv
// Multicycle MIPS control FSM (IDLE/IF/ID/EX/MEM/WB) with ready-handshaked memory.
// Define MCYCLE_CTRL_SUBWORD_EN to enable lb/lbu/lh/lhu/sb/sh.
module mcycle_ctrl
  import mcycle_pkg::*;
#(
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_rdy,
  output logic               pc_wr,
  output logic               ir_wr,
  output logic [1:0]         npc_sel,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic               iord,
  output logic               reg_wr,
  output logic [1:0]         reg_dst,
  output logic [1:0]         wd_sel,
  output logic               ext_sel,
  output logic               alu_srca,
  output logic [1:0]         alu_srcb,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               shamt_var,
  output logic               shift_right,
  output logic               shift_arith,
  output logic [1:0]         sub_size,
  output logic               sub_unsign,
  output logic               illegal,
  output logic [2:0]         state_o
);

  state_e             state_q, state_d;
  logic               illegal_q, illegal_d;
  class_e             dec_cls;
  logic [ALUOP_W-1:0] dec_alu_op;
  logic               dec_ext_sel, dec_srca, dec_shamt_var, dec_right, dec_arith;
  logic [1:0]         dec_sub_size;
  logic               dec_sub_unsign, dec_legal;

  mcycle_decode #(.ALUOP_W(ALUOP_W)) u_decode (
    .op          (op),
    .funct       (funct),
    .cls         (dec_cls),
    .alu_op      (dec_alu_op),
    .ext_sel     (dec_ext_sel),
    .alu_srca    (dec_srca),
    .shamt_var   (dec_shamt_var),
    .shift_right (dec_right),
    .shift_arith (dec_arith),
    .sub_size    (dec_sub_size),
    .sub_unsign  (dec_sub_unsign),
    .legal       (dec_legal)
  );

  always_comb begin
    state_d     = state_q;
    illegal_d   = 1'b0;
    pc_wr       = 1'b0;
    ir_wr       = 1'b0;
    npc_sel     = NPC_PC4;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    iord        = 1'b0;
    reg_wr      = 1'b0;
    reg_dst     = RD_RT;
    wd_sel      = WD_ALU;
    ext_sel     = 1'b0;
    alu_srca    = 1'b0;
    alu_srcb    = 2'd0;
    alu_op      = '0;
    shamt_var   = 1'b0;
    shift_right = 1'b0;
    shift_arith = 1'b0;
    sub_size    = SZ_WORD;
    sub_unsign  = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_IF;
      S_IF: begin
        mem_rd   = 1'b1;
        alu_srcb = 2'd2;
        alu_op   = ALUOP_W'(ALU_ADD);
        if (mem_rdy) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          state_d = S_ID;
        end
      end
      S_ID: begin
        illegal_d = !dec_legal;
        state_d   = dec_legal ? S_EX : S_IF;
      end
      S_EX: begin
        alu_op      = dec_alu_op;
        ext_sel     = dec_ext_sel;
        alu_srca    = dec_srca;
        shamt_var   = dec_shamt_var;
        shift_right = dec_right;
        shift_arith = dec_arith;
        state_d     = S_IF;
        case (dec_cls)
          CL_RALU: state_d = S_WB;
          CL_IALU: begin alu_srcb = 2'd1; state_d = S_WB; end
          CL_LOAD, CL_STORE: begin alu_srcb = 2'd1; state_d = S_MEM; end
          CL_BEQ:  begin pc_wr = zero;  npc_sel = NPC_BR; end
          CL_BNE:  begin pc_wr = !zero; npc_sel = NPC_BR; end
          CL_J:    begin pc_wr = 1'b1;  npc_sel = NPC_JMP; end
          CL_JR:   begin pc_wr = 1'b1;  npc_sel = NPC_RS; end
          CL_JAL: begin
            pc_wr = 1'b1; npc_sel = NPC_JMP;
            reg_wr = 1'b1; reg_dst = RD_RA; wd_sel = WD_PC;
          end
          CL_JALR: begin
            pc_wr = 1'b1; npc_sel = NPC_RS;
            reg_wr = 1'b1; reg_dst = RD_RD; wd_sel = WD_PC;
          end
          default: state_d = S_IF;
        endcase
      end
      S_MEM: begin
        // Request stays up every cycle in MEM until the memory answers.
        iord       = 1'b1;
        mem_rd     = (dec_cls == CL_LOAD);
        mem_wr     = (dec_cls == CL_STORE);
        sub_size   = dec_sub_size;
        sub_unsign = dec_sub_unsign;
        if (mem_rdy) state_d = (dec_cls == CL_LOAD) ? S_WB : S_IF;
      end
      S_WB: begin
        reg_wr  = 1'b1;
        reg_dst = (dec_cls == CL_RALU) ? RD_RD : RD_RT;
        wd_sel  = (dec_cls == CL_LOAD) ? WD_MDR : WD_ALU;
        state_d = S_IF;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  assign illegal = illegal_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Directed self-checking bench for mcycle_ctrl; expectations depend on whether
// MCYCLE_CTRL_SUBWORD_EN is defined for the build.
module tb_mcycle_ctrl;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_IF = 3'd1, ST_ID = 3'd2;
  localparam logic [2:0] ST_EX = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [5:0] op = 6'h00, funct = 6'h00;
  logic       zero = 1'b0, mem_rdy = 1'b0;
  logic       pc_wr, ir_wr, mem_rd, mem_wr, iord, reg_wr, ext_sel, alu_srca;
  logic [1:0] npc_sel, reg_dst, wd_sel, alu_srcb, sub_size;
  logic [3:0] alu_op;
  logic       shamt_var, shift_right, shift_arith, sub_unsign, illegal;
  logic [2:0] state_o;
  logic [26:0] all_outs;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mcycle_ctrl #(.ALUOP_W(4)) dut (
    .clk(clk), .rstn(rstn), .op(op), .funct(funct), .zero(zero), .mem_rdy(mem_rdy),
    .pc_wr(pc_wr), .ir_wr(ir_wr), .npc_sel(npc_sel), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .iord(iord), .reg_wr(reg_wr), .reg_dst(reg_dst), .wd_sel(wd_sel), .ext_sel(ext_sel),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_op(alu_op), .shamt_var(shamt_var),
    .shift_right(shift_right), .shift_arith(shift_arith), .sub_size(sub_size),
    .sub_unsign(sub_unsign), .illegal(illegal), .state_o(state_o)
  );

  assign all_outs = {pc_wr, ir_wr, npc_sel, mem_rd, mem_wr, iord, reg_wr, reg_dst, wd_sel,
                     ext_sel, alu_srca, alu_srcb, alu_op, shamt_var, shift_right,
                     shift_arith, sub_size, sub_unsign, illegal};

  // Advance one clock and land mid-cycle, away from the active edge.
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    mem_rdy = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
    n_checks++;
    if (state_o !== ST_IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d expected %0d", state_o, ST_IDLE);
    end
    n_checks++;
    if (all_outs !== 27'd0) begin
      n_fail++; $display("FAIL reset_outs: got %0h expected 0", all_outs);
    end
    $display("test_reset done");
  endtask

  task automatic test_add;
    logic [2:0] exp_st [5];
    exp_st = '{ST_IF, ST_ID, ST_EX, ST_WB, ST_IF};
    op = 6'h00; funct = 6'h20; mem_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (state_o !== exp_st[i]) begin
        n_fail++; $display("FAIL add_state[%0d]: got %0d expected %0d", i, state_o, exp_st[i]);
      end
      n_checks++;
      if (reg_wr !== (exp_st[i] == ST_WB)) begin
        n_fail++; $display("FAIL add_reg_wr[%0d]: got %0b expected %0b", i, reg_wr, exp_st[i] == ST_WB);
      end
      if (exp_st[i] == ST_WB) begin
        n_checks++;
        if (reg_dst !== 2'd1) begin
          n_fail++; $display("FAIL add_reg_dst: got %0d expected 1", reg_dst);
        end
      end
    end
    $display("test_add done");
  endtask

  task automatic test_lw_wait;
    logic [2:0] exp_st [10];
    logic       rdy [10];
    exp_st = '{ST_IF, ST_IF, ST_IF, ST_ID, ST_EX, ST_MEM, ST_MEM, ST_MEM, ST_MEM, ST_WB};
    rdy    = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    op = 6'h23; funct = 6'h00;
    // Entered already in IF from the previous test.
    for (int i = 0; i < 10; i++) begin
      mem_rdy = rdy[i];
      #1;
      n_checks++;
      if (state_o !== exp_st[i]) begin
        n_fail++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, state_o, exp_st[i]);
      end
      if (exp_st[i] == ST_IF || exp_st[i] == ST_MEM) begin
        n_checks++;
        if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || iord !== (exp_st[i] == ST_MEM)) begin
          n_fail++; $display("FAIL lw_req[%0d]: got rd=%0b wr=%0b iord=%0b expected rd=1 wr=0 iord=%0b",
                             i, mem_rd, mem_wr, iord, exp_st[i] == ST_MEM);
        end
      end
      if (exp_st[i] == ST_IF) begin
        n_checks++;
        if (ir_wr !== rdy[i] || pc_wr !== rdy[i]) begin
          n_fail++; $display("FAIL lw_ifwr[%0d]: got ir=%0b pc=%0b expected %0b", i, ir_wr, pc_wr, rdy[i]);
        end
      end
      if (exp_st[i] == ST_WB) begin
        n_checks++;
        if (reg_wr !== 1'b1 || wd_sel !== 2'd1 || reg_dst !== 2'd0) begin
          n_fail++; $display("FAIL lw_wb: got reg_wr=%0b wd_sel=%0d reg_dst=%0d expected 1/1/0",
                             reg_wr, wd_sel, reg_dst);
        end
      end
      tick();
    end
    n_checks++;
    if (state_o !== ST_IF) begin
      n_fail++; $display("FAIL lw_end: got %0d expected %0d", state_o, ST_IF);
    end
    $display("test_lw_wait done");
  endtask

  task automatic test_beq;
    logic z [2];
    z = '{1'b1, 1'b0};
    op = 6'h04; funct = 6'h00; mem_rdy = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick(); tick();
      zero = z[k];
      #1;
      n_checks++;
      if (state_o !== ST_EX || pc_wr !== z[k] || npc_sel !== 2'd1 || alu_op !== 4'd1) begin
        n_fail++; $display("FAIL beq_ex[%0d]: got st=%0d pc_wr=%0b npc=%0d alu=%0d expected st=3 pc_wr=%0b npc=1 alu=1",
                           k, state_o, pc_wr, npc_sel, alu_op, z[k]);
      end
      tick();
      n_checks++;
      if (state_o !== ST_IF) begin
        n_fail++; $display("FAIL beq_ret[%0d]: got %0d expected %0d", k, state_o, ST_IF);
      end
    end
    zero = 1'b0;
    $display("test_beq done");
  endtask

  task automatic test_jal;
    op = 6'h03; funct = 6'h00; mem_rdy = 1'b1;
    tick(); tick();
    n_checks++;
    if (state_o !== ST_EX || pc_wr !== 1'b1 || npc_sel !== 2'd2 || reg_wr !== 1'b1 ||
        reg_dst !== 2'd2 || wd_sel !== 2'd2) begin
      n_fail++; $display("FAIL jal_ex: got st=%0d pc_wr=%0b npc=%0d reg_wr=%0b dst=%0d wd=%0d expected 3/1/2/1/2/2",
                         state_o, pc_wr, npc_sel, reg_wr, reg_dst, wd_sel);
    end
    tick();
    n_checks++;
    if (state_o !== ST_IF) begin
      n_fail++; $display("FAIL jal_ret: got %0d expected %0d", state_o, ST_IF);
    end
    $display("test_jal done");
  endtask

  task automatic test_illegal;
    op = 6'h3F; funct = 6'h00; mem_rdy = 1'b1;
    tick();
    n_checks++;
    if (state_o !== ST_ID || illegal !== 1'b0 || reg_wr !== 1'b0 || mem_wr !== 1'b0) begin
      n_fail++; $display("FAIL ill_id: got st=%0d ill=%0b reg_wr=%0b mem_wr=%0b expected 2/0/0/0",
                         state_o, illegal, reg_wr, mem_wr);
    end
    mem_rdy = 1'b0;
    tick();
    n_checks++;
    if (state_o !== ST_IF || illegal !== 1'b1 || reg_wr !== 1'b0 || mem_wr !== 1'b0) begin
      n_fail++; $display("FAIL ill_pulse: got st=%0d ill=%0b reg_wr=%0b mem_wr=%0b expected 1/1/0/0",
                         state_o, illegal, reg_wr, mem_wr);
    end
    tick();
    n_checks++;
    if (state_o !== ST_IF || illegal !== 1'b0) begin
      n_fail++; $display("FAIL ill_once: got st=%0d ill=%0b expected 1/0", state_o, illegal);
    end
    $display("test_illegal done");
  endtask

  task automatic test_lbu;
    op = 6'h24; funct = 6'h00; mem_rdy = 1'b1;
    tick();
`ifdef MCYCLE_CTRL_SUBWORD_EN
    tick(); tick();
    n_checks++;
    if (state_o !== ST_MEM || sub_size !== 2'd2 || sub_unsign !== 1'b1 || mem_rd !== 1'b1) begin
      n_fail++; $display("FAIL lbu_mem: got st=%0d size=%0d uns=%0b rd=%0b expected 4/2/1/1",
                         state_o, sub_size, sub_unsign, mem_rd);
    end
    tick();
    n_checks++;
    if (state_o !== ST_WB || wd_sel !== 2'd1) begin
      n_fail++; $display("FAIL lbu_wb: got st=%0d wd=%0d expected 5/1", state_o, wd_sel);
    end
    tick();
`else
    tick();
    n_checks++;
    if (state_o !== ST_IF || illegal !== 1'b1) begin
      n_fail++; $display("FAIL lbu_illegal: got st=%0d ill=%0b expected 1/1", state_o, illegal);
    end
`endif
    n_checks++;
    if (state_o !== ST_IF || sub_size !== 2'd0) begin
      n_fail++; $display("FAIL lbu_end: got st=%0d size=%0d expected 1/0", state_o, sub_size);
    end
    $display("test_lbu done");
  endtask

  task automatic test_reset_mid;
    op = 6'h23; funct = 6'h00; mem_rdy = 1'b1;
    tick(); tick(); tick();
    mem_rdy = 1'b0;
    tick();
    n_checks++;
    if (state_o !== ST_MEM || mem_rd !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_wait: got st=%0d rd=%0b expected 4/1", state_o, mem_rd);
    end
    rstn = 1'b0;
    #1;
    n_checks++;
    if (state_o !== ST_IDLE || all_outs !== 27'd0) begin
      n_fail++; $display("FAIL rstmid_async: got st=%0d outs=%0h expected 0/0", state_o, all_outs);
    end
    mem_rdy = 1'b1;
    tick();
    rstn = 1'b1;
    #1;
    n_checks++;
    if (state_o !== ST_IDLE) begin
      n_fail++; $display("FAIL rstmid_idle: got %0d expected %0d", state_o, ST_IDLE);
    end
    tick();
    n_checks++;
    if (state_o !== ST_IF || mem_rd !== 1'b1 || iord !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_if: got st=%0d rd=%0b iord=%0b expected 1/1/0", state_o, mem_rd, iord);
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_beq();
    test_jal();
    test_illegal();
    test_lbu();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mcycle_ctrl.md
# mcycle_ctrl

Multicycle successor to the single-cycle MIPS control unit: decodes `op`/`funct` of the instruction held in the datapath IR and steps it through IF/ID/EX/MEM/WB states. It issues per-state enables, so one ALU and one unified memory serve all phases. Memory accesses use a ready handshake so variable-latency memory stalls the FSM. It sits between the IR and the multicycle datapath in the SCPU top level.

## Interface
- `ALUOP_W`, default 4: ALU operation code width. The codes are the existing ALU encoding, zero-extended.
- `clk` input 1: sole clock, rising edge.
- `rstn` input 1: asynchronous active-low reset.
- `op` input 6: IR[31:26]. Stable from the end of IF until the next IR write.
- `funct` input 6: IR[5:0].
- `zero` input 1: ALU zero flag. Sampled only in EX of beq/bne.
- `mem_rdy` input 1: memory completes the current `mem_rd`/`mem_wr` this cycle.
- `pc_wr` output 1: PC load enable.
- `ir_wr` output 1: IR load enable.
- `npc_sel` output 2: PC source. 0 = pc+4, 1 = branch target, 2 = jump target, 3 = rs.
- `mem_rd` output 1: memory read request. Held until `mem_rdy`.
- `mem_wr` output 1: memory write request. Held until `mem_rdy`.
- `iord` output 1: memory address source. 0 = PC, 1 = ALUOut.
- `reg_wr` output 1: register file write enable.
- `reg_dst` output 2: destination register. 0 = rt, 1 = rd, 2 = $31.
- `wd_sel` output 2: write-back data. 0 = ALUOut, 1 = MDR, 2 = PC (already pc+4).
- `ext_sel` output 1: immediate extension. 1 = sign, 0 = zero.
- `alu_srca` output 1: ALU operand A. 0 = rs, 1 = shifter path.
- `alu_srcb` output 2: ALU operand B. 0 = rt, 1 = extended immediate, 2 = constant 4.
- `alu_op` output ALUOP_W: ALU operation.
- `shamt_var` output 1: shift amount source. 1 = rs (sllv/srlv/srav), 0 = shamt field.
- `shift_right` output 1: shift direction. 1 = right.
- `shift_arith` output 1: 1 = arithmetic shift (sra/srav).
- `sub_size` output 2: access size. 0 = word, 1 = half, 2 = byte.
- `sub_unsign` output 1: 1 = lbu/lhu.
- `illegal` output 1: one-cycle pulse on an undecodable instruction.
- `state_o` output 3: current state, for debug and the testbench.

## Operation
- States: S_IDLE, S_IF, S_ID, S_EX, S_MEM, S_WB.
- S_IDLE:
  - Entered on reset. All outputs are 0.
  - Unconditionally goes to S_IF on the next edge.
- S_IF:
  - Drives `mem_rd=1`, `iord=0`, `alu_srcb=2`, `alu_op`=add.
  - On `mem_rdy`: `ir_wr=1`, `pc_wr=1`, `npc_sel=0`, then go to S_ID.
  - Without `mem_rdy`: stay in S_IF with `ir_wr` and `pc_wr` at 0.
- S_ID:
  - Decodes the instruction. Register reads are latched by the datapath.
  - Undecodable `op`/`funct`: pulse `illegal`, return to S_IF. The instruction acts as a nop.
  - Otherwise go to S_EX.
- S_EX, per class:
  - R-ALU and shifts: ALU controls as in the existing decode, then go to S_WB.
  - I-ALU (addi/andi/ori/slti/lui): `alu_srcb=1`; `ext_sel=1` only for addi/slti; then go to S_WB.
  - Load/store: address add with `ext_sel=1`, then go to S_MEM.
  - beq/bne: subtract; `pc_wr` = (beq & `zero`) | (bne & !`zero`); `npc_sel=1`; then go to S_IF.
  - j: `pc_wr=1`, `npc_sel=2`, then go to S_IF.
  - jr: `pc_wr=1`, `npc_sel=3`, then go to S_IF.
  - jal: `pc_wr=1`, `npc_sel=2`, plus `reg_wr=1`, `reg_dst=2`, `wd_sel=2`, then go to S_IF.
  - jalr: `pc_wr=1`, `npc_sel=3`, plus `reg_wr=1`, `reg_dst=1`, `wd_sel=2`, then go to S_IF.
- S_MEM:
  - Drives `iord=1` with `mem_rd` (load) or `mem_wr` (store); `sub_size` and `sub_unsign` are valid.
  - On `mem_rdy`: a load goes to S_WB, a store goes to S_IF.
- S_WB:
  - `reg_wr=1` for one cycle.
  - `reg_dst`=1 for R-type, 0 otherwise; `wd_sel`=1 for loads, 0 otherwise.
  - Then go to S_IF.
- Request rules:
  - `mem_rd`/`mem_wr` are never both high.
  - A request is never dropped before `mem_rdy`.
  - `mem_rdy` outside S_IF/S_MEM is ignored.
- Output derivation: outputs are combinational from the state register plus `op`/`funct`, except `illegal`, which is registered.
- Reset mid-wait: `rstn` low at any time forces S_IDLE asynchronously and all outputs to 0 immediately. The pending memory request is abandoned.

## Timing
- Latency with zero-wait memory:
  - R/I-ALU: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch, j, jr, jal, jalr: 3 cycles.
  - Illegal: 2 cycles.
- Each cycle `mem_rdy` is low in S_IF or S_MEM adds exactly one cycle.
- `illegal` goes high in the cycle after S_ID and lasts exactly one cycle.
- `pc_wr` and `reg_wr` are never asserted in the same cycle, except in EX of jal/jalr.

## Configuration
- Macro: `MCYCLE_CTRL_SUBWORD_EN`.
- Defined: lb/lbu/lh/lhu/sb/sh decode as above with `sub_size`/`sub_unsign`.
- Undefined:
  - Those opcodes raise `illegal`.
  - `sub_size` and `sub_unsign` are tied to 0.

## Structure
- Shared package `mcycle_pkg`:
  - State enum.
  - Opcode and funct constants.
  - ALU op codes.
  - `npc_sel`, `reg_dst` and `wd_sel` encodings.
- One sub-module `mcycle_decode`: combinational class decode of `op`/`funct`. Outputs: class, `alu_op`, `ext_sel`, shift flags, sub-word fields, `legal`.
- The FSM lives in `mcycle_ctrl`.

## Test plan
- Reset, add (op 0, funct 0x20), `mem_rdy`=1: `state_o` sequence IDLE,IF,ID,EX,WB,IF; `reg_wr` high only in WB with `reg_dst`=1.
- lw (0x23) with `mem_rdy` low 2 cycles in IF and 3 in MEM: 10 cycles total; `mem_rd` held throughout both waits.
- beq with `zero`=1, then `zero`=0: `pc_wr`=1 with `npc_sel`=1 in EX for the first; `pc_wr`=0 for the second; both return to IF.
- jal (0x03): in EX, `pc_wr`=1, `npc_sel`=2, `reg_wr`=1, `reg_dst`=2, `wd_sel`=2 in one cycle.
- op 0x3F: `illegal` is one cycle high; no `reg_wr`/`mem_wr`; back in IF.
- lbu (0x24) built without `MCYCLE_CTRL_SUBWORD_EN` → `illegal`. Built with it → `sub_size`=2, `sub_unsign`=1 in MEM.
- `rstn` low while in MEM waiting → outputs 0 at once; S_IDLE, then S_IF after release.
